// File: rtl/reflet_irq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : reflet_irq_ctrl
//  Brief    : Edge-detecting, masked, fixed-priority interrupt controller with
//             CPU req/ack handshake and memory-mapped CTRL/MASK/PENDING/STATUS/EOI.
//  Revision : 1.0  initial release
// ============================================================================
module reflet_irq_ctrl #(
  parameter int                        WORDSIZE       = 16,
  parameter int                        BASE_ADDR_SIZE = 16,
  parameter logic [BASE_ADDR_SIZE-1:0] BASE_ADDR      = 'hFF00,
  parameter int                        N_IRQ          = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_enable,
  input  logic [N_IRQ-1:0]          i_irq_in,
  input  logic [BASE_ADDR_SIZE-1:0] i_addr,
  input  logic                      i_write_en,
  input  logic [WORDSIZE-1:0]       i_data_in,
  output logic [WORDSIZE-1:0]       o_data_out,
  output logic                      o_cpu_irq,
  output logic [2:0]                o_cpu_irq_num,
  input  logic                      i_cpu_ack
);

  localparam logic [1:0] C_IDLE    = 2'd0;
  localparam logic [1:0] C_REQ     = 2'd1;
  localparam logic [1:0] C_SERVICE = 2'd2;

  localparam logic [2:0] C_OFF_CTRL    = 3'd0;
  localparam logic [2:0] C_OFF_MASK    = 3'd1;
  localparam logic [2:0] C_OFF_PENDING = 3'd2;
  localparam logic [2:0] C_OFF_STATUS  = 3'd3;
  localparam logic [2:0] C_OFF_EOI     = 3'd4;

  logic [1:0]       r_state;
  logic [2:0]       r_num;
  logic             r_ge;
  logic [N_IRQ-1:0] r_mask;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_irq_q;

  logic [BASE_ADDR_SIZE-1:0] w_offset;
  logic                      w_sel;
  logic                      w_wr;
  logic [N_IRQ-1:0]          w_edge;
  logic [N_IRQ-1:0]          w_pm;
  logic [N_IRQ-1:0]          w_num_bit;
  logic [N_IRQ-1:0]          w_w1c;
  logic [N_IRQ-1:0]          w_ack_clr;
  logic                      w_live;
  logic                      w_cand_vld;
  logic [2:0]                w_cand;
  logic                      w_svc;
  logic                      w_unused_data;

  // Offset only meaningful once addr >= BASE_ADDR, so no wraparound concern.
  assign w_offset = i_addr - BASE_ADDR;
  assign w_sel    = i_enable && (i_addr >= BASE_ADDR) && (w_offset < BASE_ADDR_SIZE'(5));
  assign w_wr     = w_sel && i_write_en;

  assign w_edge    = i_irq_in & ~r_irq_q;
  assign w_pm      = r_pending & r_mask & {N_IRQ{r_ge}};
  assign w_num_bit = N_IRQ'(1) << r_num;
  assign w_live    = |(w_pm & w_num_bit);
  assign w_svc     = (r_state == C_SERVICE);

  assign w_w1c     = (w_wr && w_offset[2:0] == C_OFF_PENDING) ? i_data_in[N_IRQ-1:0] : '0;
  assign w_ack_clr = (r_state == C_REQ && w_live && i_cpu_ack) ? w_num_bit : '0;

  assign w_unused_data = ^i_data_in;

  always_comb begin
    w_cand     = 3'd0;
    w_cand_vld = |w_pm;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_pm[i]) w_cand = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_q   <= '0;
      r_ge      <= 1'b0;
      r_mask    <= '0;
      r_pending <= '0;
    end else begin
      r_irq_q <= i_irq_in;
      if (w_wr && w_offset[2:0] == C_OFF_CTRL) r_ge   <= i_data_in[0];
      if (w_wr && w_offset[2:0] == C_OFF_MASK) r_mask <= i_data_in[N_IRQ-1:0];
      // New edges win over any clear in the same cycle so no event is lost.
      r_pending <= (r_pending & ~w_w1c & ~w_ack_clr) | w_edge;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= C_IDLE;
      r_num   <= 3'd0;
    end else begin
      case (r_state)
        C_IDLE: begin
          if (w_cand_vld) begin
            r_state <= C_REQ;
            r_num   <= w_cand;
          end
        end
        C_REQ: begin
          if (!w_live)        r_state <= C_IDLE;
          else if (i_cpu_ack) r_state <= C_SERVICE;
        end
        C_SERVICE: begin
          if (w_wr && w_offset[2:0] == C_OFF_EOI) r_state <= C_IDLE;
        end
        default: r_state <= C_IDLE;
      endcase
    end
  end

  assign o_cpu_irq     = (r_state == C_REQ);
  assign o_cpu_irq_num = r_num;

  always_comb begin
    o_data_out = '0;
    if (w_sel) begin
      case (w_offset[2:0])
        C_OFF_CTRL:    o_data_out[0]         = r_ge;
        C_OFF_MASK:    o_data_out[N_IRQ-1:0] = r_mask;
        C_OFF_PENDING: o_data_out[N_IRQ-1:0] = r_pending;
        C_OFF_STATUS: begin
          o_data_out[7]   = w_svc;
          o_data_out[2:0] = w_svc ? r_num : 3'd0;
        end
        default:       o_data_out = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reflet_irq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_reflet_irq_ctrl
//  Brief    : Directed self-checking bench for reflet_irq_ctrl (scoreboard queue).
//  Revision : 1.0  initial release
// ============================================================================
module tb_reflet_irq_ctrl;

  localparam logic [15:0] BASE = 16'hFF00;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_enable = 1'b1;
  logic [3:0]  i_irq_in = '0;
  logic [15:0] i_addr = '0;
  logic        i_write_en = 1'b0;
  logic [15:0] i_data_in = '0;
  logic [15:0] o_data_out;
  logic        o_cpu_irq;
  logic [2:0]  o_cpu_irq_num;
  logic        i_cpu_ack = 1'b0;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  reflet_irq_ctrl #(
    .WORDSIZE(16), .BASE_ADDR_SIZE(16), .BASE_ADDR(BASE), .N_IRQ(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_irq_in(i_irq_in),
    .i_addr(i_addr), .i_write_en(i_write_en), .i_data_in(i_data_in),
    .o_data_out(o_data_out), .o_cpu_irq(o_cpu_irq),
    .o_cpu_irq_num(o_cpu_irq_num), .i_cpu_ack(i_cpu_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic chk(input logic [15:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
    end else begin
      e = sb_q.pop_front();
      n_cmp++;
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic wr(input logic [2:0] off, input logic [15:0] d);
    i_addr     = BASE + 16'(off);
    i_data_in  = d;
    i_write_en = 1'b1;
    tick();
    i_write_en = 1'b0;
    i_data_in  = '0;
  endtask

  task automatic rd_chk(input logic [15:0] a, input string tag, input logic [15:0] v);
    push(tag, v);
    i_addr = a;
    #1;
    chk(o_data_out);
  endtask

  task automatic irq_chk(input string tag, input logic v);
    push(tag, {15'd0, v});
    chk({15'd0, o_cpu_irq});
  endtask

  task automatic num_chk(input string tag, input logic [2:0] v);
    push(tag, {13'd0, v});
    chk({13'd0, o_cpu_irq_num});
  endtask

  task automatic ack();
    i_cpu_ack = 1'b1;
    tick();
    i_cpu_ack = 1'b0;
  endtask

  initial begin
    #12;
    irq_chk("rst_cpu_irq", 1'b0);
    num_chk("rst_num", 3'd0);
    rst_n = 1'b1;
    tick();
    rd_chk(BASE + 16'd0, "rst_ctrl", 16'h0000);
    rd_chk(BASE + 16'd3, "rst_status", 16'h0000);

    // Basic request/ack/EOI on line 0
    wr(3'd0, 16'h0001);
    wr(3'd1, 16'h0001);
    i_irq_in = 4'b0001;
    tick();
    i_irq_in = 4'b0000;
    irq_chk("basic_n1_low", 1'b0);
    tick();
    irq_chk("basic_n2_high", 1'b1);
    num_chk("basic_num", 3'd0);
    ack();
    irq_chk("basic_svc_low", 1'b0);
    rd_chk(BASE + 16'd2, "basic_pend_clr", 16'h0000);
    rd_chk(BASE + 16'd3, "basic_status_svc", 16'h0080);
    wr(3'd4, 16'h0000);
    rd_chk(BASE + 16'd3, "basic_status_eoi", 16'h0000);
    tick();
    irq_chk("basic_after_eoi", 1'b0);

    // Priority: lines 3 and 1 together
    wr(3'd1, 16'h000F);
    i_irq_in = 4'b1010;
    tick();
    i_irq_in = 4'b0000;
    tick();
    irq_chk("prio_req1", 1'b1);
    num_chk("prio_num1", 3'd1);
    ack();
    rd_chk(BASE + 16'd2, "prio_pend_left", 16'h0008);
    rd_chk(BASE + 16'd3, "prio_status1", 16'h0081);
    wr(3'd4, 16'h0000);
    tick();
    irq_chk("prio_req3", 1'b1);
    num_chk("prio_num3", 3'd3);
    ack();
    wr(3'd4, 16'h0000);

    // Masking
    wr(3'd1, 16'h0000);
    i_irq_in = 4'b0100;
    tick();
    i_irq_in = 4'b0000;
    tick();
    tick();
    rd_chk(BASE + 16'd2, "mask_pend", 16'h0004);
    irq_chk("mask_no_req", 1'b0);
    wr(3'd1, 16'h0004);
    irq_chk("mask_unmask_n1", 1'b0);
    tick();
    irq_chk("mask_unmask_n2", 1'b1);
    num_chk("mask_num", 3'd2);
    ack();
    wr(3'd4, 16'h0000);

    // Race: new edge beats w1c, then request withdrawal
    wr(3'd1, 16'h0000);
    i_irq_in = 4'b0001;
    tick();
    i_irq_in = 4'b0000;
    tick();
    i_irq_in = 4'b0001;
    wr(3'd2, 16'h0001);
    i_irq_in = 4'b0000;
    rd_chk(BASE + 16'd2, "race_pend", 16'h0001);
    wr(3'd1, 16'h0001);
    tick();
    irq_chk("wd_req", 1'b1);
    wr(3'd2, 16'h0001);
    tick();
    irq_chk("wd_withdrawn", 1'b0);
    rd_chk(BASE + 16'd3, "wd_status", 16'h0000);

    // Bus gating and level-held line
    wr(3'd1, 16'h0000);
    i_enable = 1'b0;
    wr(3'd1, 16'h000F);
    i_enable = 1'b1;
    rd_chk(BASE + 16'd1, "bus_mask_kept", 16'h0000);
    rd_chk(BASE + 16'd5, "bus_out_of_range", 16'h0000);
    i_irq_in = 4'b0010;
    repeat (4) tick();
    rd_chk(BASE + 16'd2, "level_pend", 16'h0002);
    wr(3'd2, 16'h0002);
    repeat (3) tick();
    rd_chk(BASE + 16'd2, "level_once", 16'h0000);
    i_irq_in = 4'b0000;
    tick();

    // Async reset mid-REQ
    wr(3'd1, 16'h0002);
    i_irq_in = 4'b0010;
    tick();
    i_irq_in = 4'b0000;
    tick();
    irq_chk("rst_pre_req", 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    irq_chk("rst_irq_drop", 1'b0);
    rd_chk(BASE + 16'd0, "rst2_ctrl", 16'h0000);
    rd_chk(BASE + 16'd1, "rst2_mask", 16'h0000);
    rd_chk(BASE + 16'd2, "rst2_pend", 16'h0000);
    rd_chk(BASE + 16'd3, "rst2_status", 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();
    irq_chk("rst_after_release", 1'b0);

    if (sb_q.size() != 0) begin
      n_err++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
